cam_pixel_framer: RTL
=====================

Name: cam_pixel_framer

Overview:
- Upstream stage of blurring_filter: converts the camera byte stream (RGB565, two bytes per pixel) into a framed 12-bit RGB444 pixel stream.
- Drives the filter's ready_in, data_in and freq_flag.
- Tracks pixel and line position and reports framing errors.
- Latches the requested kernel size only at frame start, so the filter never changes kernel mid-frame.

Parameters:
- IMG_WIDTH, 640, active pixels per line.
- IMG_HEIGHT, 480, active lines per frame.
- XW, $clog2(IMG_WIDTH), width of x_count.
- YW, $clog2(IMG_HEIGHT), width of y_count.

Ports:
- clk  in  1  system clock; all inputs are already synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- cam_vsync  in  1  high during vertical blanking; its falling edge starts a frame.
- cam_href  in  1  high while line bytes are valid.
- cam_byte_valid  in  1  byte strobe; cam_data is sampled only when this and cam_href are both 1.
- cam_data  in  8  camera byte.
- freq_req  in  3  requested kernel code.
- ready_out  out  1  one-cycle strobe: data_out is a valid pixel (connects to the filter's ready_in).
- data_out  out  12  RGB444 pixel {R[3:0],G[3:0],B[3:0]}.
- freq_flag  out  3  kernel code latched for the current frame.
- sof  out  1  high together with ready_out on pixel (0,0).
- eol  out  1  high together with ready_out on the last pixel of a line (x = IMG_WIDTH-1).
- x_count  out  XW  x position of the pixel currently on data_out.
- y_count  out  YW  y position of the pixel currently on data_out.
- frame_err  out  1  sticky error for the current frame.

Behaviour:
- Reset (asynchronous, rst_n = 0): state = SYNC. All outputs are 0: ready_out, data_out, freq_flag, sof, eol, x_count, y_count, frame_err.
- States:
  - SYNC: wait for cam_vsync = 1, then go to VBLANK. Entered after reset so that a partially seen frame is never emitted.
  - VBLANK: on the cam_vsync falling edge (registered previous value 1, current 0), latch freq_flag, clear frame_err and the line counter, then go to LINE_WAIT.
  - LINE_WAIT: on cam_href rising, clear the pixel counter and go to HI_BYTE.
  - HI_BYTE: on an accepted byte, store it in hi_reg and go to LO_BYTE.
  - LO_BYTE: on an accepted byte, form the pixel and go to HI_BYTE.
  - In HI_BYTE or LO_BYTE, cam_href falling ends the line and returns to LINE_WAIT.
  - cam_vsync = 1 in any state other than SYNC forces VBLANK.
- Pixel packing:
  - hi = RRRRRGGG, lo = GGGBBBBB.
  - R = hi[7:4], G = {hi[2:0], lo[7]}, B = lo[4:1].
- Output timing: data_out, ready_out, sof, eol, x_count and y_count are registered. ready_out is 1 on the cycle after the low byte is accepted (latency 1 from the low-byte cycle), for exactly one cycle.
- data_out holds its last value when ready_out = 0.
- freq_flag is stable for the whole frame:
  - latched from freq_req at the vsync falling edge only;
  - codes above 3'b010 are clamped to 3'b010.
- Line and pixel limits:
  - Lines with index ≥ IMG_HEIGHT are consumed but not emitted (no ready_out), and frame_err is set.
  - Pixels with index ≥ IMG_WIDTH in a line are dropped, and frame_err is set.
- Errors at cam_href falling (stray bytes accepted while in LINE_WAIT or VBLANK are ignored and do not set frame_err):
  - state LO_BYTE (odd byte count): the half pixel is discarded, frame_err is set.
  - pixel count < IMG_WIDTH (short line): frame_err is set, y still advances.
- Simultaneous events:
  - cam_vsync = 1 while cam_href = 1: vsync wins; the line is aborted, frame_err is set, go to VBLANK.
  - A byte accepted on the same cycle as cam_href falling is not accepted (cam_href gates it).
- frame_err is held until the next vsync falling edge clears it.
- rst_n asserted mid-line: everything clears immediately; nothing is emitted until a full vsync high→low is seen.

Test Plan (IMG_WIDTH = 4, IMG_HEIGHT = 2, one byte per cycle):
1. Reset, then vsync 1→0, then two lines of bytes F8,00 / 07,E0 / 00,1F / FF,FF. Required: 8 ready_out pulses. Per line, data_out = F00, 0F0, 00F, FFF; eol on x = 3; sof only on the first pixel; frame_err = 0.
2. freq_req = 3'b001 at the vsync edge, changed to 3'b010 mid-frame. Required: freq_flag = 001 for the whole frame and 010 after the next vsync falling edge. Also freq_req = 3'b111 at the edge → freq_flag = 010.
3. Line of 7 bytes (odd). Required: 3 pixels emitted, half pixel dropped, frame_err = 1 until the next vsync falling edge clears it.
4. Line of 5 pixels, then a third line. Required: 4 pixels emitted for that line; the third line produces no ready_out; frame_err = 1.
5. rst_n pulsed low after 3 bytes of line 0, released while cam_vsync = 0 and the line continues. Required: no ready_out until cam_vsync goes 1→0; the next frame then emits normally starting at x = 0, y = 0.
6. cam_vsync raised while cam_href = 1 mid-line. Required: no further pixels, frame_err = 1, state VBLANK; the following frame is clean and frame_err reads 0 after its vsync falling edge.

Source files
------------

// File: rtl/cam_pixel_framer.sv
// Camera byte framer: RGB565 byte pairs in, framed RGB444 pixels out, with pixel/line
// position, a kernel code frozen at frame start and a sticky per-frame error flag.
module cam_pixel_framer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int XW         = $clog2(IMG_WIDTH),
  parameter int YW         = $clog2(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic          cam_byte_valid,
  input  logic [7:0]    cam_data,
  input  logic [2:0]    freq_req,
  output logic          ready_out,
  output logic [11:0]   data_out,
  output logic [2:0]    freq_flag,
  output logic          sof,
  output logic          eol,
  output logic [XW-1:0] x_count,
  output logic [YW-1:0] y_count,
  output logic          frame_err
);
  typedef enum logic [2:0] {SYNC, VBLANK, LINE_WAIT, HI_BYTE, LO_BYTE} state_t;

  typedef struct packed {
    logic          rdy;
    logic          sof;
    logic          eol;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [11:0]   data;
  } pix_out_t;

  // Counters carry one extra bit so they can sit at the limit and flag overflow.
  localparam logic [XW:0] X_LIM = IMG_WIDTH[XW:0];
  localparam logic [YW:0] Y_LIM = IMG_HEIGHT[YW:0];

  state_t      state_q, state_d;
  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic [7:0]  hi_q, hi_d;
  logic [XW:0] pix_q, pix_d;
  logic [YW:0] line_q, line_d;
  logic [2:0]  freq_q, freq_d;
  logic        err_q, err_d;
  pix_out_t    out_q, out_d;

  logic        byte_ok, vs_fall, href_rise, href_fall;
  logic        end_line, emit;
  logic [11:0] pixel;
  logic        unused_bits;

  assign byte_ok     = cam_href & cam_byte_valid;
  assign vs_fall     = vsync_q & ~cam_vsync;
  assign href_rise   = ~href_q & cam_href;
  assign href_fall   = href_q & ~cam_href;
  assign pixel       = {hi_q[7:4], hi_q[2:0], cam_data[7], cam_data[4:1]};
  assign unused_bits = ^{cam_data[6:5], cam_data[0], hi_q[3]};

  always_comb begin
    state_d  = state_q;
    vsync_d  = cam_vsync;
    href_d   = cam_href;
    hi_d     = hi_q;
    pix_d    = pix_q;
    line_d   = line_q;
    freq_d   = freq_q;
    err_d    = err_q;
    end_line = 1'b0;
    emit     = 1'b0;
    case (state_q)
      SYNC: if (cam_vsync) state_d = VBLANK;
      VBLANK: begin
        if (vs_fall) begin
          freq_d  = (freq_req > 3'd2) ? 3'd2 : freq_req;
          err_d   = 1'b0;
          line_d  = '0;
          state_d = LINE_WAIT;
        end
      end
      LINE_WAIT: begin
        if (href_rise) begin
          pix_d   = '0;
          state_d = HI_BYTE;
          if (line_q >= Y_LIM) err_d = 1'b1;
        end
      end
      HI_BYTE: begin
        if (href_fall) end_line = 1'b1;
        else if (byte_ok) begin
          hi_d    = cam_data;
          state_d = LO_BYTE;
        end
      end
      LO_BYTE: begin
        if (href_fall) begin
          end_line = 1'b1;
          err_d    = 1'b1;
        end else if (byte_ok) begin
          state_d = HI_BYTE;
          if (pix_q < X_LIM) begin
            emit  = (line_q < Y_LIM);
            pix_d = pix_q + 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = SYNC;
    endcase

    if (end_line) begin
      state_d = LINE_WAIT;
      if (pix_q < X_LIM) err_d = 1'b1;
      if (line_q < Y_LIM) line_d = line_q + 1'b1;
    end

    // vsync overrides everything; an open line is aborted and its pixel dropped.
    if (cam_vsync && state_q != SYNC) begin
      state_d = VBLANK;
      emit    = 1'b0;
      if ((state_q == HI_BYTE || state_q == LO_BYTE) && cam_href) err_d = 1'b1;
    end

    out_d     = out_q;
    out_d.rdy = 1'b0;
    out_d.sof = 1'b0;
    out_d.eol = 1'b0;
    if (emit) begin
      out_d.rdy  = 1'b1;
      out_d.data = pixel;
      out_d.x    = pix_q[XW-1:0];
      out_d.y    = line_q[YW-1:0];
      out_d.sof  = (pix_q == '0) && (line_q == '0);
      out_d.eol  = (pix_q == X_LIM - 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SYNC;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      hi_q    <= '0;
      pix_q   <= '0;
      line_q  <= '0;
      freq_q  <= '0;
      err_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      hi_q    <= hi_d;
      pix_q   <= pix_d;
      line_q  <= line_d;
      freq_q  <= freq_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  assign ready_out = out_q.rdy;
  assign data_out  = out_q.data;
  assign sof       = out_q.sof;
  assign eol       = out_q.eol;
  assign x_count   = out_q.x;
  assign y_count   = out_q.y;
  assign freq_flag = freq_q;
  assign frame_err = err_q;
endmodule
